// File: rtl/sat_round.sv
// sat_round: narrowing requantizer between the MAC accumulator and the FIR
// output port. A wide signed sample is rounded (SHIFT fractional LSBs
// dropped) in stage 1, then clamped to OUTPUT_WIDTH bits in stage 2 (the
// output register). The pipeline is a 2-deep valid/ready chain. A saturating
// counter tallies clamped beats that are taken downstream.
//
// Build option: SAT_ROUND_CONVERGENT_EN -- when defined, stage 1 rounds
// half-to-even instead of half-up. Timing and handshake are unchanged.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   din/din_valid/din_ready     input stream (INPUT_WIDTH signed)
//   dout/dout_valid/dout_ready  output stream (OUTPUT_WIDTH signed)
//   dout_sat            current output beat was clamped
//   sat_clear           synchronous clear of sat_count
//   sat_count           clamped beats accepted downstream, sticks at max
module sat_round #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT        = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sat,
  input  logic                    sat_clear,
  output logic [CNT_WIDTH-1:0]    sat_count
);
  // Width of the rounded value; one guard bit above the input keeps the
  // rounding add from wrapping.
  localparam int RW = INPUT_WIDTH + 1 - SHIFT;
  localparam int EW = INPUT_WIDTH + 1;

  logic          s1_valid;
  logic [RW-1:0] s1_r;
  logic          s1_en, s2_en;

  logic [EW-1:0] ext, rc, sum;
  logic [RW-1:0] r;

  // Stage 1 combinational: sign-extend, add rounding constant, drop LSBs.
  always_comb begin
    ext = {din[INPUT_WIDTH-1], din};
`ifdef SAT_ROUND_CONVERGENT_EN
    // Half-to-even: a tie only carries up when the kept LSB is already odd.
    rc  = (EW'(1) << (SHIFT - 1)) - EW'(1) + EW'(din[SHIFT]);
`else
    rc  = EW'(1) << (SHIFT - 1);
`endif
    sum = ext + rc;
    r   = sum[EW-1:SHIFT];
  end

  // Discarded fractional bits, kept visible only to mark them as intentional.
  logic unused_frac;
  assign unused_frac = ^sum[SHIFT-1:0];

  // Stage 2 combinational: the value fits iff every bit from the output sign
  // position up to the top of r agrees.
  logic [RW-OUTPUT_WIDTH:0] hi;
  logic                     in_range;
  logic [OUTPUT_WIDTH-1:0]  q;

  always_comb begin
    hi       = s1_r[RW-1:OUTPUT_WIDTH-1];
    in_range = (&hi) | ~(|hi);
    if (in_range)
      q = s1_r[OUTPUT_WIDTH-1:0];
    else if (s1_r[RW-1])
      q = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    else
      q = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  end

  // Handshake: each stage advances when its downstream slot is free or
  // draining this cycle. din_ready is combinational from dout_ready.
  assign s2_en     = !dout_valid || dout_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign din_ready = s1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_r       <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sat   <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= din_valid;
        if (din_valid) s1_r <= r;
      end
      if (s2_en) begin
        dout_valid <= s1_valid;
        if (s1_valid) begin
          dout     <= q;
          dout_sat <= ~in_range;
        end
      end
    end
  end

  // Counts clamped beats only when they actually leave; clear has priority.
  logic sat_xfer;
  assign sat_xfer = dout_valid && dout_ready && dout_sat;

  always_ff @(posedge clk) begin
    if (rst || sat_clear)
      sat_count <= '0;
    else if (sat_xfer && (sat_count != {CNT_WIDTH{1'b1}}))
      sat_count <= sat_count + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_sat_round.sv
module tb_sat_round;
  logic        clk = 1'b0;
  logic        rst, din_valid, dout_ready, sat_clear;
  logic [31:0] din;
  logic        din_ready, dout_valid, dout_sat;
  logic [15:0] dout, sat_count;
  logic        din_ready2, dout_valid2, dout_sat2;
  logic [15:0] dout2;
  logic [1:0]  sat_count2;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  sat_round dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sat(dout_sat), .sat_clear(sat_clear), .sat_count(sat_count));

  // Narrow counter instance sharing the same stimulus.
  sat_round #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready2),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready),
    .dout_sat(dout_sat2), .sat_clear(sat_clear), .sat_count(sat_count2));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference requantizer: {sat, dout}.
  function automatic logic [16:0] model(input logic [31:0] x);
    longint v, r;
    v = longint'($signed(x));
`ifdef SAT_ROUND_CONVERGENT_EN
    r = (v + 64'sd16383 + longint'(x[15])) >>> 15;
`else
    r = (v + 64'sd16384) >>> 15;
`endif
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  task automatic test_reset;
    rst = 1; din = '0; din_valid = 0; dout_ready = 0; sat_clear = 0;
    step; step;
    rst = 0;
    #1;
    total++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || dout_sat !== 1'b0 ||
        sat_count !== 16'h0 || din_ready !== 1'b1)
      begin bad++; $display("FAIL reset got dout=%h v=%b s=%b cnt=%h rdy=%b exp 0000 0 0 0000 1",
                            dout, dout_valid, dout_sat, sat_count, din_ready); end
  endtask

  task automatic test_rounding;
    logic [31:0] v [4];
    logic [15:0] e [4];
    v = '{32'h00004000, 32'h0000C000, 32'hFFFFC000, 32'hFFFF4000};
`ifdef SAT_ROUND_CONVERGENT_EN
    e = '{16'h0000, 16'h0002, 16'h0000, 16'hFFFE};
`else
    e = '{16'h0001, 16'h0002, 16'h0000, 16'hFFFF};
`endif
    dout_ready = 1;
    for (int i = 0; i < 4; i++) begin
      din = v[i]; din_valid = 1;
      step;
      din_valid = 0;
      total++;
      if (dout_valid !== 1'b0)
        begin bad++; $display("FAIL round_latency[%0d] got valid=%b exp 0", i, dout_valid); end
      step;
      total++;
      if (dout_valid !== 1'b1 || dout !== e[i] || dout_sat !== 1'b0)
        begin bad++; $display("FAIL round[%0d] din=%h got v=%b dout=%h sat=%b exp 1 %h 0",
                              i, v[i], dout_valid, dout, dout_sat, e[i]); end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] v [6];
    logic [15:0] e [6];
    logic        s [6];
    v = '{32'h7FFFFFFF, 32'h80000000, 32'h3FFF8000, 32'h3FFFC000, 32'hC0000000, 32'hBFFF8000};
    e = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dout_ready = 1;
    for (int i = 0; i < 6; i++) begin
      din = v[i]; din_valid = 1;
      step;
      din_valid = 0;
      step;
      total++;
      if (dout_valid !== 1'b1 || dout !== e[i] || dout_sat !== s[i])
        begin bad++; $display("FAIL sat[%0d] din=%h got v=%b dout=%h sat=%b exp 1 %h %b",
                              i, v[i], dout_valid, dout, dout_sat, e[i], s[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v [4];
    logic [15:0] e [4];
    v = '{32'h00010000, 32'h00018000, 32'hFFFF0000, 32'h7FFFFFFF};
    e = '{16'h0002, 16'h0003, 16'hFFFE, 16'h7FFF};
    dout_ready = 1;
    for (int k = 0; k < 6; k++) begin
      din_valid = (k < 4);
      if (k < 4) din = v[k];
      #1;
      if (k < 4) begin
        total++;
        if (din_ready !== 1'b1)
          begin bad++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, din_ready); end
      end
      if (k >= 2) begin
        total++;
        if (dout_valid !== 1'b1 || dout !== e[k-2])
          begin bad++; $display("FAIL b2b_out[%0d] got v=%b dout=%h exp 1 %h",
                                k-2, dout_valid, dout, e[k-2]); end
      end
      step;
    end
    din_valid = 0;
  endtask

  task automatic test_backpressure;
    logic [31:0] v [4];
    int acc;
    v = '{32'h00020000, 32'hFFFE0000, 32'h00030000, 32'h00040000};
    acc = 0;
    din_valid = 0; dout_ready = 1;
    step; step;
    dout_ready = 0; din_valid = 1;
    for (int c = 0; c < 5; c++) begin
      din = v[acc];
      #1;
      if (din_ready) acc++;
      step;
    end
    total++;
    if (acc !== 2 || din_ready !== 1'b0)
      begin bad++; $display("FAIL bp_absorb got accepted=%0d rdy=%b exp 2 0", acc, din_ready); end
    total++;
    if (dout_valid !== 1'b1 || dout !== 16'h0004)
      begin bad++; $display("FAIL bp_hold got v=%b dout=%h exp 1 0004", dout_valid, dout); end
    din_valid = 0; dout_ready = 1;
    #1;
    total++;
    if (din_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release got rdy=%b exp 1", din_ready); end
    step;
    total++;
    if (dout_valid !== 1'b1 || dout !== 16'hFFFC)
      begin bad++; $display("FAIL bp_second got v=%b dout=%h exp 1 fffc", dout_valid, dout); end
    step;
    total++;
    if (dout_valid !== 1'b0)
      begin bad++; $display("FAIL bp_dup got v=%b exp 0", dout_valid); end
  endtask

  task automatic test_stream;
    logic [16:0] q[$];
    logic [31:0] rv;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while ((sent < 100 || q.size() > 0) && cyc < 2000) begin
      rv = $urandom;
      din_valid = (sent < 100);
      din = (sent % 2) ? {{9{rv[22]}}, rv[22:0]} : rv;
      dout_ready = 1'($urandom_range(0, 1));
      #1;
      if (dout_valid && dout_ready) begin
        total++;
        if (q.size() == 0)
          begin bad++; $display("FAIL stream_extra got dout=%h exp none", dout); end
        else begin
          if ({dout_sat, dout} !== q[0])
            begin bad++; $display("FAIL stream[%0d] got %h exp %h", got, {dout_sat, dout}, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (din_valid && din_ready) begin
        q.push_back(model(din));
        sent++;
      end
      step;
      cyc++;
    end
    din_valid = 0; dout_ready = 1;
    total++;
    if (sent != 100 || got != 100 || q.size() != 0)
      begin bad++; $display("FAIL stream_count got sent=%0d out=%0d pending=%0d exp 100 100 0",
                            sent, got, q.size()); end
  endtask

  task automatic test_counter;
    din_valid = 0; dout_ready = 1; sat_clear = 1;
    step; step; step;
    sat_clear = 0;
    total++;
    if (sat_count !== 16'd0 || sat_count2 !== 2'd0)
      begin bad++; $display("FAIL cnt_clear got %0d/%0d exp 0/0", sat_count, sat_count2); end
    din = 32'h7FFFFFFF;
    for (int i = 0; i < 3; i++) begin din_valid = 1; step; end
    din_valid = 0;
    step; step; step;
    total++;
    if (sat_count !== 16'd3 || sat_count2 !== 2'd3)
      begin bad++; $display("FAIL cnt_three got %0d/%0d exp 3/3", sat_count, sat_count2); end
    din = 32'h80000000;
    for (int i = 0; i < 2; i++) begin din_valid = 1; step; end
    din_valid = 0;
    step; step; step;
    total++;
    if (sat_count !== 16'd5 || sat_count2 !== 2'd3)
      begin bad++; $display("FAIL cnt_sticky got %0d/%0d exp 5/3", sat_count, sat_count2); end
    din = 32'h7FFFFFFF; din_valid = 1;
    step;
    din_valid = 0;
    step;
    sat_clear = 1;
    step;
    sat_clear = 0;
    total++;
    if (sat_count !== 16'd0 || sat_count2 !== 2'd0)
      begin bad++; $display("FAIL cnt_clear_wins got %0d/%0d exp 0/0", sat_count, sat_count2); end
  endtask

  task automatic test_reset_midflight;
    int stale;
    stale = 0;
    din = 32'h7FFFFFFF; din_valid = 1; dout_ready = 1;
    step;
    din_valid = 0;
    step; step;
    total++;
    if (sat_count !== 16'd1)
      begin bad++; $display("FAIL mid_pre got cnt=%0d exp 1", sat_count); end
    dout_ready = 0; din_valid = 1;
    step; step;
    #1;
    total++;
    if (din_ready !== 1'b0 || dout_valid !== 1'b1)
      begin bad++; $display("FAIL mid_full got rdy=%b v=%b exp 0 1", din_ready, dout_valid); end
    din_valid = 0; rst = 1;
    step;
    rst = 0;
    total++;
    if (dout_valid !== 1'b0 || dout !== 16'h0 || sat_count !== 16'h0 || din_ready !== 1'b1)
      begin bad++; $display("FAIL mid_reset got v=%b dout=%h cnt=%h rdy=%b exp 0 0000 0000 1",
                            dout_valid, dout, sat_count, din_ready); end
    dout_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      if (dout_valid) stale++;
    end
    total++;
    if (stale != 0)
      begin bad++; $display("FAIL mid_stale got %0d beats exp 0", stale); end
  endtask

  initial begin
    test_reset;
    test_rounding;
    test_saturation;
    test_back_to_back;
    test_backpressure;
    test_stream;
    test_counter;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
